ifu_fetch: RTL and testbench

//  Instruction fetch unit: supplier side of the fetch->decode interface. Generates sequential PCs,

---
 rtl/ifu_fetch_pkg.sv | 21 ++
 rtl/ifu_fifo.sv | 59 +++++
 rtl/ifu_fetch.sv | 131 +++++++++++++
 tb/tb_ifu_fetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitCredit
  } req_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous response buffer with clear; same-cycle push+pop keeps the count.
module ifu_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues sequential imem requests, buffers in-order responses for decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = PC_RESET,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fc_stall_if_i,
  input  logic        fc_flush_if_i,
  input  logic [31:0] fc_redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifu_ready_o,
  output logic [31:0] ifu_inst_o,
  output logic [31:0] ifu_pc_o
);

  localparam int unsigned OutW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);

  req_state_e          state_q, state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [OutW-1:0]     outstanding_q, outstanding_d, discard_q, discard_d;
  logic [FifoCntW-1:0] fifo_count;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  fetch_entry_t        fifo_head;
  logic                handshake, rsp_valid, credit_ok;
  logic [31:0]         inflight;

  assign handshake = imem_req_o & imem_gnt_i;
  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_valid = imem_rvalid_i & (outstanding_q != '0);
  assign fifo_pop  = ifu_ready_o & ~fc_stall_if_i;

  // Every live in-flight request must own a FIFO slot, so stalls can never overflow it.
  always_comb begin
    inflight  = 32'(outstanding_q) - 32'(discard_q) + 32'(fifo_count);
    credit_ok = (32'(outstanding_q) < MAX_OUTSTANDING) && (inflight < FIFO_DEPTH) && !fifo_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:              state_d = StReq;
      StReq, StWaitCredit: state_d = credit_ok ? StReq : StWaitCredit;
      default:             state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req_o  = (state_q != StIdle) && credit_ok && !fc_flush_if_i;
    imem_addr_o = fetch_pc_q;
    ifu_ready_o = !fifo_empty && !fc_flush_if_i;
    ifu_pc_o    = fifo_head.pc;
    ifu_inst_o  = fifo_head.inst;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (handshake && !rsp_valid) begin
      outstanding_d = outstanding_q + OutW'(1);
    end else if (!handshake && rsp_valid) begin
      outstanding_d = outstanding_q - OutW'(1);
    end
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    fifo_push  = 1'b0;
    if (fc_flush_if_i) begin
      // Everything still in flight after this edge is stale; this cycle's response is dropped.
      discard_d  = outstanding_d;
      fetch_pc_d = pc_align(fc_redirect_pc_i);
      rsp_pc_d   = pc_align(fc_redirect_pc_i);
    end else begin
      if (handshake) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - OutW'(1);
        end else begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  ifu_fifo #(
    .Width($bits(fetch_entry_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (fifo_push),
    .wdata_i({rsp_pc_q, imem_rdata_i}),
    .pop_i  (fifo_pop),
    .clear_i(fc_flush_if_i),
    .rdata_o(fifo_head),
    .count_o(fifo_count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  rvalid_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid_i |-> outstanding_q != '0);

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed sequences, redirect vectors, randomized traffic.
module tb_ifu_fetch;

  localparam logic [31:0] RstPc  = 32'h0000_0000;
  localparam int          Depth  = 2;
  localparam int          MaxOut = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fc_stall_if_i, fc_flush_if_i;
  logic [31:0] fc_redirect_pc_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        ifu_ready_o;
  logic [31:0] ifu_inst_o, ifu_pc_o;

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_PC       (RstPc),
    .FIFO_DEPTH     (Depth),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fc_stall_if_i   (fc_stall_if_i),
    .fc_flush_if_i   (fc_flush_if_i),
    .fc_redirect_pc_i(fc_redirect_pc_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .ifu_ready_o     (ifu_ready_o),
    .ifu_inst_o      (ifu_inst_o),
    .ifu_pc_o        (ifu_pc_o)
  );

  typedef struct {
    logic [31:0] redir;
    logic [31:0] exp_pc0;
    logic [31:0] exp_pc1;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Memory model and reference state.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          gnt_pct = 100;
  int          dly_min = 0, dly_max = 0;
  logic [31:0] exp_addr = RstPc;
  logic [31:0] exp_pc = RstPc;
  int          pops = 0;

  // Sampled values of the current cycle and the previous one.
  logic        s_req, s_ready, hs;
  logic [31:0] s_addr, s_pc, s_inst;
  logic        p_req = 0, p_gnt = 0, p_hold = 0;
  logic [31:0] p_addr = 0, p_pc = 0, p_inst = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    chk(pend_addr.size() <= MaxOut, "outstanding_bound", 32'(pend_addr.size()), 32'(MaxOut));
    if (fc_flush_if_i) chk(!s_req, "no_req_in_flush", {31'd0, s_req}, 32'd0);
    if (p_req && !p_gnt && !fc_flush_if_i) begin
      chk(s_req, "req_held", {31'd0, s_req}, 32'd1);
      chk(s_addr == p_addr, "addr_held", s_addr, p_addr);
    end
    if (p_hold && !fc_flush_if_i) begin
      chk(s_ready && s_pc == p_pc && s_inst == p_inst, "stall_frozen", s_pc, p_pc);
    end
    if (s_req && imem_gnt_i) begin
      chk(s_addr == exp_addr, "grant_addr", s_addr, exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
    if (s_ready && !fc_stall_if_i) begin
      chk(s_pc == exp_pc, "pop_pc", s_pc, exp_pc);
      chk(s_inst == inst_of(exp_pc), "pop_inst", s_inst, inst_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
  endtask

  // Called just after a rising edge with this cycle's inputs already driven.
  task automatic tick();
    logic rv, fl;
    logic [31:0] fl_pc;
    @(negedge clk);
    s_req = imem_req_o; s_addr = imem_addr_o;
    s_ready = ifu_ready_o; s_pc = ifu_pc_o; s_inst = ifu_inst_o;
    monitor();
    hs = s_req && imem_gnt_i;
    rv = imem_rvalid_i;
    fl = fc_flush_if_i;
    fl_pc = {fc_redirect_pc_i[31:2], 2'b00};
    p_req = s_req; p_gnt = imem_gnt_i; p_addr = s_addr;
    p_hold = s_ready && fc_stall_if_i && !fc_flush_if_i;
    p_pc = s_pc; p_inst = s_inst;
    @(posedge clk);
    #1;
    cyc++;
    if (rv) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (hs) begin
      pend_addr.push_back(s_addr);
      pend_due.push_back(cyc + int'($urandom_range(dly_max, dly_min)));
    end
    if (fl) begin
      exp_addr = fl_pc;
      exp_pc   = fl_pc;
    end
    imem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    if (pend_addr.size() > 0) begin
      if (pend_due[0] <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = inst_of(pend_addr[0]);
      end
    end
  endtask

  task automatic expect_next_pc(input logic [31:0] exp, input string name);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (s_ready && !fc_stall_if_i) begin
        chk(s_pc == exp, name, s_pc, exp);
        return;
      end
    end
    chk(1'b0, {name, "_timeout"}, 32'd0, exp);
  endtask

  task automatic clear_model();
    pend_addr.delete();
    pend_due.delete();
    exp_addr = RstPc; exp_pc = RstPc;
    p_req = 0; p_gnt = 0; p_hold = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    fc_stall_if_i = 0; fc_flush_if_i = 0;
  endtask

  vec_t vecs[4];

  initial begin
    int first_ready, grants, budget;
    vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};
    vecs[3] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0044};

    rst_n = 0; fc_redirect_pc_i = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk(!imem_req_o, "rst_req", {31'd0, imem_req_o}, 32'd0);
    chk(!ifu_ready_o, "rst_ready", {31'd0, ifu_ready_o}, 32'd0);
    chk(ifu_inst_o == 0, "rst_inst", ifu_inst_o, 32'd0);
    chk(ifu_pc_o == 0, "rst_pc", ifu_pc_o, 32'd0);
    chk(imem_addr_o == RstPc, "rst_addr", imem_addr_o, RstPc);
    rst_n = 1;

    // Basic stream: gnt always, response one cycle after grant.
    first_ready = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_ready && first_ready < 0) first_ready = i;
    end
    chk(first_ready == 3, "first_ready_cycle", 32'(first_ready), 32'd3);

    // Stall with head pc 0x8.
    budget = 0;
    while (exp_pc != 32'h8 && budget < 40) begin tick(); budget++; end
    fc_stall_if_i = 1; grants = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (hs) grants++; end
    chk(s_ready && s_pc == 32'h8, "stall_head_pc", s_pc, 32'h8);
    chk(grants <= Depth - 1, "stall_grants", 32'(grants), 32'(Depth - 1));
    fc_stall_if_i = 0;
    budget = 0;
    while (exp_pc != 32'h14 && budget < 40) begin tick(); budget++; end
    chk(exp_pc == 32'h14, "post_stall_stream", exp_pc, 32'h14);

    // Redirect vectors.
    foreach (vecs[i]) begin
      fc_flush_if_i = 1; fc_redirect_pc_i = vecs[i].redir;
      tick();
      fc_flush_if_i = 0;
      expect_next_pc(vecs[i].exp_pc0, "redir_pc0");
      expect_next_pc(vecs[i].exp_pc1, "redir_pc1");
    end

    // Flush with two requests outstanding; both stale responses must vanish.
    dly_min = 3; dly_max = 3;
    budget = 0;
    while (pend_addr.size() != 2 && budget < 40) begin tick(); budget++; end
    chk(pend_addr.size() == 2, "two_outstanding", 32'(pend_addr.size()), 32'd2);
    fc_flush_if_i = 1; fc_redirect_pc_i = 32'h0000_0103;
    tick();
    fc_flush_if_i = 0;
    expect_next_pc(32'h0000_0100, "flush_outstanding_pc");

    // Flush coinciding with gnt and rvalid.
    dly_min = 0; dly_max = 0;
    budget = 0;
    while (!imem_rvalid_i && budget < 40) begin tick(); budget++; end
    chk(imem_rvalid_i, "rvalid_for_flush", {31'd0, imem_rvalid_i}, 32'd1);
    imem_gnt_i = 1; fc_flush_if_i = 1; fc_redirect_pc_i = 32'h0000_0200;
    tick();
    fc_flush_if_i = 0;
    expect_next_pc(32'h0000_0200, "flush_rvalid_pc");
    expect_next_pc(32'h0000_0204, "flush_rvalid_pc1");

    // Randomized traffic against the reference stream.
    gnt_pct = 60; dly_min = 0; dly_max = 4;
    pops = 0; budget = 0;
    while (pops < 1000 && budget < 30000) begin
      fc_stall_if_i = ($urandom_range(0, 99) < 20);
      fc_flush_if_i = ($urandom_range(0, 99) < 2);
      fc_redirect_pc_i = $urandom;
      tick();
      budget++;
    end
    fc_stall_if_i = 0; fc_flush_if_i = 0;
    chk(pops >= 1000, "random_pops", 32'(pops), 32'd1000);

    // Asynchronous reset in the middle of a pending request.
    gnt_pct = 0;
    repeat (3) tick();
    #3;
    rst_n = 0;
    #1;
    chk(!imem_req_o, "mid_rst_req", {31'd0, imem_req_o}, 32'd0);
    chk(!ifu_ready_o, "mid_rst_ready", {31'd0, ifu_ready_o}, 32'd0);
    chk(ifu_inst_o == 0, "mid_rst_inst", ifu_inst_o, 32'd0);
    chk(ifu_pc_o == 0, "mid_rst_pc", ifu_pc_o, 32'd0);
    clear_model();
    gnt_pct = 100; dly_min = 0; dly_max = 2;
    @(posedge clk);
    #1;
    rst_n = 1;
    expect_next_pc(RstPc, "refetch_reset_pc");
    expect_next_pc(RstPc + 32'd4, "refetch_next_pc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
